// File: rtl/sipo_deserializer.sv
// sipo_deserializer
// Serial-in / parallel-out word assembler. Collects WIDTH bits from the
// upstream flip-flop's registered output and hands each completed word to a
// consumer through a single-entry holding register with a valid/ready
// handshake. A word that completes while the holding register is still
// occupied, and is not being taken on that edge, is dropped and flagged by
// the sticky overrun flag.

module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_serial_in,
  input  logic                       i_shift_en,
  input  logic                       i_clear,
  input  logic                       i_data_ready,
  output logic [WIDTH-1:0]           o_data_out,
  output logic                       o_data_valid,
  output logic                       o_overrun,
  output logic [$clog2(WIDTH+1)-1:0] o_bit_count
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  // State
  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_bit_count;
  logic [WIDTH-1:0] r_data_out;
  logic             r_data_valid;
  logic             r_overrun;

  // Next-state and qualifier wires
  logic [WIDTH-1:0] w_sr_next;
  logic [WIDTH-1:0] w_sr_d;
  logic [CW-1:0]    w_bit_count_d;
  logic [WIDTH-1:0] w_data_out_d;
  logic             w_data_valid_d;
  logic             w_overrun_d;
  logic             w_accept;
  logic             w_complete;
  logic             w_take;

  // Shift-register next value in the configured bit order
  always_comb begin
    w_sr_next = r_sr;
    if (MSB_FIRST) begin
      w_sr_next = {r_sr[WIDTH-2:0], i_serial_in};
    end else begin
      w_sr_next = {i_serial_in, r_sr[WIDTH-1:1]};
    end
  end

  // Handshake and word-completion qualifiers; clear suppresses any completion
  always_comb begin
    w_accept   = i_shift_en & ~i_clear;
    w_complete = w_accept & (r_bit_count == LAST_BIT);
    w_take     = r_data_valid & i_data_ready;
  end

  // Shift register and bit counter next state; clear wins over shift_en
  always_comb begin
    w_sr_d        = r_sr;
    w_bit_count_d = r_bit_count;
    if (i_clear) begin
      w_sr_d        = {WIDTH{1'b0}};
      w_bit_count_d = {CW{1'b0}};
    end else if (i_shift_en) begin
      w_sr_d = w_sr_next;
      if (w_complete) begin
        w_bit_count_d = {CW{1'b0}};
      end else begin
        w_bit_count_d = r_bit_count + CW'(1);
      end
    end else begin
      w_sr_d        = r_sr;
      w_bit_count_d = r_bit_count;
    end
  end

  // Holding register: load on completion if empty or being emptied, else drop
  always_comb begin
    w_data_out_d   = r_data_out;
    w_data_valid_d = r_data_valid;
    if (w_complete) begin
      if (!r_data_valid || w_take) begin
        w_data_out_d   = w_sr_next;
        w_data_valid_d = 1'b1;
      end else begin
        w_data_out_d   = r_data_out;
        w_data_valid_d = r_data_valid;
      end
    end else if (w_take) begin
      w_data_valid_d = 1'b0;
    end else begin
      w_data_valid_d = r_data_valid;
    end
  end

  // Sticky overrun: set when a completed word is dropped, cleared only by clear
  always_comb begin
    w_overrun_d = r_overrun;
    if (i_clear) begin
      w_overrun_d = 1'b0;
    end else if (w_complete && r_data_valid && !w_take) begin
      w_overrun_d = 1'b1;
    end else begin
      w_overrun_d = r_overrun;
    end
  end

  // State registers with asynchronous reset discarding any partial word
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sr         <= {WIDTH{1'b0}};
      r_bit_count  <= {CW{1'b0}};
      r_data_out   <= {WIDTH{1'b0}};
      r_data_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_sr         <= w_sr_d;
      r_bit_count  <= w_bit_count_d;
      r_data_out   <= w_data_out_d;
      r_data_valid <= w_data_valid_d;
      r_overrun    <= w_overrun_d;
    end
  end

  assign o_data_out   = r_data_out;
  assign o_data_valid = r_data_valid;
  assign o_overrun    = r_overrun;
  assign o_bit_count  = r_bit_count;

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer
// Directed bench for sipo_deserializer. Two instances (MSB-first and
// LSB-first, WIDTH=8) share all inputs. A vector table covers assembly and
// shift gaps; hand-written sequences cover overrun, back-to-back transfer,
// clear and asynchronous reset.

module tb_sipo_deserializer;

  logic       clk;
  logic       rst;
  logic       serial_in;
  logic       shift_en;
  logic       clear;
  logic       data_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ovr;
  logic [3:0] m_cnt;
  logic [7:0] l_data;
  logic       l_valid;
  logic       l_ovr;
  logic [3:0] l_cnt;

  int n_checks;
  int n_fail;

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .i_clk(clk), .i_rst(rst), .i_serial_in(serial_in), .i_shift_en(shift_en),
    .i_clear(clear), .i_data_ready(data_ready), .o_data_out(m_data),
    .o_data_valid(m_valid), .o_overrun(m_ovr), .o_bit_count(m_cnt)
  );

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .i_clk(clk), .i_rst(rst), .i_serial_in(serial_in), .i_shift_en(shift_en),
    .i_clear(clear), .i_data_ready(data_ready), .o_data_out(l_data),
    .o_data_valid(l_valid), .o_overrun(l_ovr), .o_bit_count(l_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       din;
    logic       rdy;
    logic       clr;
    logic [7:0] exp_msb;
    logic [7:0] exp_lsb;
    logic       exp_valid;
    logic [3:0] exp_cnt;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input logic b, input logic rdy);
    serial_in  = b;
    shift_en   = 1'b1;
    clear      = 1'b0;
    data_ready = rdy;
    step();
  endtask

  // Shift 8 bits MSB-first in time; ready is applied only on the last edge
  task automatic shift_word(input logic [7:0] w, input logic rdy_last);
    for (int i = 7; i >= 0; i--) begin
      shift_bit(w[i], (i == 0) ? rdy_last : 1'b0);
    end
  endtask

  task automatic idle(input logic rdy);
    shift_en   = 1'b0;
    clear      = 1'b0;
    data_ready = rdy;
    serial_in  = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #7;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic add_vec(input logic en, input logic din, input logic rdy, input logic clr,
                         input logic [7:0] em, input logic [7:0] el, input logic ev,
                         input logic [3:0] ec, input logic eo);
    vec_t v;
    v.en = en; v.din = din; v.rdy = rdy; v.clr = clr;
    v.exp_msb = em; v.exp_lsb = el; v.exp_valid = ev; v.exp_cnt = ec; v.exp_ovr = eo;
    vecs.push_back(v);
  endtask

  initial begin
    logic [7:0] pat;
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    serial_in  = 1'b0;
    shift_en   = 1'b0;
    clear      = 1'b0;
    data_ready = 1'b0;
    pat        = 8'hB2;

    // Table: plain assembly of 1,0,1,1,0,0,1,0 with ready held high
    for (int i = 0; i < 8; i++) begin
      if (i < 7) add_vec(1'b1, pat[7-i], 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 4'(i + 1), 1'b0);
      else       add_vec(1'b1, pat[7-i], 1'b1, 1'b0, 8'hB2, 8'h4D, 1'b1, 4'd0, 1'b0);
    end
    add_vec(1'b0, 1'b0, 1'b1, 1'b0, 8'hB2, 8'h4D, 1'b0, 4'd0, 1'b0);
    // Table: same stream with shift_en toggling 1,0
    for (int i = 0; i < 8; i++) begin
      add_vec(1'b1, pat[7-i], 1'b1, 1'b0, 8'hB2, 8'h4D, (i == 7), 4'((i + 1) % 8), 1'b0);
      add_vec(1'b0, 1'b1, 1'b1, 1'b0, 8'hB2, 8'h4D, 1'b0, 4'((i + 1) % 8), 1'b0);
    end

    // Reset state
    #3;
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_cnt", 32'(m_cnt), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_ovr", 32'(m_ovr), 32'd0);
    do_reset();

    foreach (vecs[k]) begin
      shift_en   = vecs[k].en;
      serial_in  = vecs[k].din;
      data_ready = vecs[k].rdy;
      clear      = vecs[k].clr;
      step();
      check($sformatf("vec%0d_msb_data", k), 32'(m_data), 32'(vecs[k].exp_msb));
      check($sformatf("vec%0d_lsb_data", k), 32'(l_data), 32'(vecs[k].exp_lsb));
      check($sformatf("vec%0d_valid", k), 32'(m_valid), 32'(vecs[k].exp_valid));
      check($sformatf("vec%0d_lsb_valid", k), 32'(l_valid), 32'(vecs[k].exp_valid));
      check($sformatf("vec%0d_cnt", k), 32'(m_cnt), 32'(vecs[k].exp_cnt));
      check($sformatf("vec%0d_ovr", k), 32'(m_ovr), 32'(vecs[k].exp_ovr));
    end

    // Overrun: A5 then 3C with ready low throughout
    do_reset();
    shift_word(8'hA5, 1'b0);
    check("ovr_first_data", 32'(m_data), 32'hA5);
    check("ovr_first_valid", 32'(m_valid), 32'd1);
    shift_word(8'h3C, 1'b0);
    check("ovr_data", 32'(m_data), 32'hA5);
    check("ovr_valid", 32'(m_valid), 32'd1);
    check("ovr_flag", 32'(m_ovr), 32'd1);
    idle(1'b0);
    check("ovr_sticky", 32'(m_ovr), 32'd1);
    idle(1'b1);
    check("ovr_take_valid", 32'(m_valid), 32'd0);
    check("ovr_after_take", 32'(m_ovr), 32'd1);
    clear = 1'b1; shift_en = 1'b0; data_ready = 1'b0;
    step();
    check("ovr_cleared", 32'(m_ovr), 32'd0);

    // Back-to-back: ready high only on the 16th edge
    do_reset();
    shift_word(8'hA5, 1'b0);
    shift_word(8'h3C, 1'b1);
    check("b2b_data", 32'(m_data), 32'h3C);
    check("b2b_valid", 32'(m_valid), 32'd1);
    check("b2b_ovr", 32'(m_ovr), 32'd0);
    idle(1'b1);
    check("b2b_drain", 32'(m_valid), 32'd0);
    check("b2b_hold", 32'(m_data), 32'h3C);

    // Clear with a pending word
    do_reset();
    shift_word(8'h11, 1'b0);
    shift_bit(1'b1, 1'b0);
    shift_bit(1'b1, 1'b0);
    shift_bit(1'b1, 1'b0);
    check("clr_pre_cnt", 32'(m_cnt), 32'd3);
    clear = 1'b1; shift_en = 1'b1; serial_in = 1'b1; data_ready = 1'b0;
    step();
    check("clr_cnt", 32'(m_cnt), 32'd0);
    check("clr_data", 32'(m_data), 32'h11);
    check("clr_valid", 32'(m_valid), 32'd1);
    for (int i = 0; i < 8; i++) shift_bit(1'b1, 1'b1);
    check("clr_next_data", 32'(m_data), 32'hFF);
    check("clr_next_valid", 32'(m_valid), 32'd1);
    check("clr_next_ovr", 32'(m_ovr), 32'd0);
    check("clr_next_cnt", 32'(m_cnt), 32'd0);

    // Asynchronous reset mid-word, between edges
    for (int i = 0; i < 5; i++) shift_bit(1'b1, 1'b0);
    check("arst_pre_cnt", 32'(m_cnt), 32'd5);
    check("arst_pre_data", 32'(m_data), 32'hFF);
    shift_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_cnt", 32'(m_cnt), 32'd0);
    check("arst_data", 32'(m_data), 32'd0);
    check("arst_valid", 32'(m_valid), 32'd0);
    check("arst_ovr", 32'(m_ovr), 32'd0);
    @(posedge clk);
    #1;
    check("arst_hold_valid", 32'(m_valid), 32'd0);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Parameterized serial-in/parallel-out deserializer that sits directly downstream of the master-slave D flip-flop stage. It consumes the flip-flop's registered serial bit, assembles WIDTH-bit words, and presents each completed word in a holding register using a valid/ready handshake. Overrun is flagged when a word completes while the previous word has not been taken.

## Interface

- WIDTH, 8, word length in bits; legal range 2..32
- MSB_FIRST, 1, 1: first received bit lands in data_out[WIDTH-1]; 0: first received bit lands in data_out[0]
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset; clears all state immediately
- serial_in  input  1  serial data bit, driven by the upstream flip-flop's q
- shift_en  input  1  when 1 at a rising edge, serial_in is sampled as the next bit
- clear  input  1  synchronous abort; empties the shift register and clears overrun
- data_ready  input  1  consumer accepts data_out when data_valid && data_ready at an edge
- data_out  output  WIDTH  holding register; last completed word
- data_valid  output  1  holding register occupied
- overrun  output  1  sticky; a completed word was dropped
- bit_count  output  $clog2(WIDTH+1)  bits currently collected in the shift register, 0..WIDTH-1

## Operation

- Storage: shift register sr[WIDTH-1:0], counter bit_count, holding register data_out, flags data_valid and overrun.
- Reset (rst=1, any time, asynchronous): sr=0, bit_count=0, data_out=0, data_valid=0, overrun=0. A partially assembled word is discarded. Outputs stay at their reset values while rst is high.
- Shift, MSB_FIRST=1: sr_next = {sr[WIDTH-2:0], serial_in}.
- Shift, MSB_FIRST=0: sr_next = {serial_in, sr[WIDTH-1:1]}.
- Bit accept: when shift_en=1 and clear=0, sr takes sr_next.
  - If bit_count < WIDTH-1, bit_count increments.
  - If bit_count == WIDTH-1, the word is complete. bit_count wraps to 0, and sr_next is offered to the holding register on the same edge.
- Holding register, evaluated at each edge where a word completes (C) and/or a take occurs (T = data_valid && data_ready):
  - C=1, data_valid=0: data_out = sr_next, data_valid = 1.
  - C=1, T=1: data_out = sr_next, data_valid stays 1. This is a back-to-back transfer, with no overrun.
  - C=1, data_valid=1, T=0: the new word is dropped, data_out is unchanged, and overrun is set to 1.
  - C=0, T=1: data_valid = 0, and data_out keeps its last value.
- clear=1 (synchronous, takes priority over shift_en): sr=0, bit_count=0, overrun=0. data_out and data_valid are unaffected, so a pending word can still be taken during clear.
- overrun is cleared only by rst or clear.
- shift_en=0: sr and bit_count hold. The handshake still operates.
- data_out must not change while data_valid=1, except on a C=1, T=1 edge.

## Timing

- Latency: data_valid rises on the same rising edge that samples bit number WIDTH. It is visible in the following cycle.
- Maximum throughput: one bit per cycle (shift_en held at 1). One word is produced every WIDTH cycles, with no stall required, provided the consumer takes each word within WIDTH cycles.
- data_ready may be held at 1 continuously. data_valid is then high for exactly one cycle per word.
- data_valid does not depend combinationally on data_ready. All outputs are registered.
- Reset release: the first sampled bit is the one present at the first rising edge with rst=0 and shift_en=1.

## Test plan

- Reset: assert rst mid-word (bit_count=5), asynchronously, between edges -> bit_count, data_out, data_valid and overrun read 0 before the next edge.
- Assembly, MSB_FIRST=1, WIDTH=8: shift 1,0,1,1,0,0,1,0 on consecutive edges with data_ready=1 -> data_out=8'hB2, data_valid high for exactly one cycle after the 8th edge.
- Assembly, MSB_FIRST=0, WIDTH=8: same bit stream -> data_out=8'h4D.
- Gaps and wrap: same stream with shift_en toggling 1,0 -> data_out=8'hB2 after the 8th accepted bit; bit_count sequence 0..7 then 0.
- Overrun and back-to-back:
  - Setup: data_ready=0, stream 8'hA5 then 8'h3C.
  - Required: data_out=8'hA5, data_valid=1, overrun=1 after the 16th bit.
  - Variant: data_ready=1 exactly on the 16th edge -> data_out=8'h3C, data_valid stays 1, overrun=0.
- Clear: pulse clear after 3 bits with a pending word 8'h11 -> bit_count=0, data_out=8'h11 still valid. The next 8 bits (8'hFF) complete normally.
